// File: rtl/wb_mprj_xbar.sv
// Wishbone fan-out from the management-SoC slave port to NCH user peripherals,
// with decode-miss/timeout abort. Optional per-channel ack counters: WB_MPRJ_XBAR_STATS_EN.
module wb_mprj_xbar #(
  parameter int unsigned       NCH      = 4,
  parameter int unsigned       DW       = 32,
  parameter int unsigned       AW       = 32,
  parameter logic [AW-1:0]     BASE     = 32'h3000_0000,
  parameter int unsigned       SEL_LSB  = 20,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DW-1:0]     ERR_DATA = 32'hDEAD_BEEF,
  localparam int unsigned      CB       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [DW/8-1:0]      wbs_sel_i,
  input  logic [AW-1:0]        wbs_adr_i,
  input  logic [DW-1:0]        wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [DW-1:0]        wbs_dat_o,
  output logic [NCH-1:0]       m_cyc_o,
  output logic [NCH-1:0]       m_stb_o,
  output logic                 m_we_o,
  output logic [DW/8-1:0]      m_sel_o,
  output logic [AW-1:0]        m_adr_o,
  output logic [DW-1:0]        m_dat_o,
  input  logic [NCH*DW-1:0]    m_dat_i,
  input  logic [NCH-1:0]       m_ack_i,
  output logic                 err_o,
`ifdef WB_MPRJ_XBAR_STATS_EN
  output logic [CB-1:0]        to_ch_o,
  input  logic                 stat_clr_i,
  output logic [NCH*16-1:0]    stat_o
`else
  output logic [CB-1:0]        to_ch_o
`endif
);

  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam int unsigned CNTW = (CB + 8 > TW) ? CB + 8 : TW;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic [CB-1:0]     ch_q;
  logic [CNTW-1:0]   cnt_q;

  logic              req, hit, ack_sel, timeout_hit;
  logic [CB-1:0]     adr_ch;
  logic [NCH-1:0]    onehot;
  logic [DW-1:0]     dat_sel;
  logic              ev_hit, ev_miss, ev_abort, ev_ack, ev_to;

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Decode and event generation; the !wbs_ack_o term blocks re-capturing the
  // request still on the bus during the upstream ack cycle.
  always_comb begin
    req         = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    adr_ch      = wbs_adr_i[SEL_LSB +: CB];
    hit         = (wbs_adr_i[AW-1:SEL_LSB+CB] == BASE[AW-1:SEL_LSB+CB]) &&
                  (int'(adr_ch) < int'(NCH));
    onehot      = NCH'(1) << adr_ch;
    ack_sel     = m_ack_i[ch_q];
    dat_sel     = m_dat_i[ch_q*DW +: DW];
    timeout_hit = (cnt_q == CNTW'(TIMEOUT - 1));
    ev_hit      = (state_q == IDLE) && req && hit;
    ev_miss     = (state_q == IDLE) && req && !hit;
    ev_abort    = (state_q == REQ) && !wbs_cyc_i;
    ev_ack      = (state_q == REQ) && wbs_cyc_i && ack_sel;
    ev_to       = (state_q == REQ) && wbs_cyc_i && !ack_sel && timeout_hit;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ev_hit)       state_d = REQ;
        else if (ev_miss) state_d = RESP;
      end
      REQ: begin
        if (ev_abort)             state_d = IDLE;
        else if (ev_ack || ev_to) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_cyc_o   <= '0;
      m_stb_o   <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      err_o     <= 1'b0;
      to_ch_o   <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
    end else begin
      wbs_ack_o <= (state_q == RESP);
      err_o     <= 1'b0;
      if (state_q == IDLE && req) begin
        m_adr_o <= wbs_adr_i;
        m_we_o  <= wbs_we_i;
        m_sel_o <= wbs_sel_i;
        m_dat_o <= wbs_dat_i;
        ch_q    <= adr_ch;
        cnt_q   <= '0;
      end
      if (ev_hit) begin
        m_cyc_o <= onehot;
        m_stb_o <= onehot;
      end
      if (ev_miss) begin
        wbs_dat_o <= ERR_DATA;
        err_o     <= 1'b1;
      end
      if (state_q == REQ) cnt_q <= cnt_q + 1'b1;
      if (ev_abort || ev_ack || ev_to) begin
        m_cyc_o <= '0;
        m_stb_o <= '0;
      end
      if (ev_ack) wbs_dat_o <= dat_sel;
      if (ev_to) begin
        wbs_dat_o <= ERR_DATA;
        err_o     <= 1'b1;
        to_ch_o   <= ch_q;
      end
    end
  end

`ifdef WB_MPRJ_XBAR_STATS_EN
  logic [15:0] stat_q [NCH];

  // Clear has priority over a same-cycle increment; counters saturate.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (stat_clr_i)
          stat_q[i] <= '0;
        else if (ev_ack && ch_q == CB'(i) && stat_q[i] != '1)
          stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_o = '0;
    for (int unsigned i = 0; i < NCH; i++) stat_o[i*16 +: 16] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_wb_mprj_xbar.sv
// Directed bench for wb_mprj_xbar (NCH=4, TIMEOUT=8): hit, write, miss,
// timeout, upstream abort, mid-transaction reset, and optional counters.
module tb_wb_mprj_xbar;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [3:0]   m_cyc, m_stb;
  logic         m_we;
  logic [3:0]   m_sel;
  logic [31:0]  m_adr, m_dat;
  logic [127:0] m_dat_i;
  logic [3:0]   m_ack_i;
  logic         err;
  logic [1:0]   to_ch;
`ifdef WB_MPRJ_XBAR_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_mprj_xbar #(.NCH(4), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .err_o(err),
`ifdef WB_MPRJ_XBAR_STATS_EN
    .to_ch_o(to_ch), .stat_clr_i(stat_clr), .stat_o(stat)
`else
    .to_ch_o(to_ch)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; wdat = d;
  endtask

  task automatic idle_bus;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Zero-wait read: ack presented in the first strobe cycle, upstream ack two edges later.
  task automatic read_ack(input string tag, input logic [31:0] a, input int ch, input logic [31:0] d);
    start(a, 1'b0, 4'hF, 32'h0);
    tick;
    chk({tag, "_stb"}, 64'(m_stb), 64'(4'b1 << ch));
    m_ack_i = 4'b1 << ch;
    m_dat_i[ch*32 +: 32] = d;
    tick;
    m_ack_i = '0;
    chk({tag, "_noack_early"}, 64'(ack), 64'd0);
    tick;
    chk({tag, "_ack"}, 64'({ack, rdat}), 64'({1'b1, d}));
    idle_bus;
    tick;
    chk({tag, "_ack_drop"}, 64'(ack), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; m_dat_i = '0; m_ack_i = '0;
    adr = '0; wdat = '0; sel = '0;
    idle_bus;
`ifdef WB_MPRJ_XBAR_STATS_EN
    stat_clr = 1'b0;
`endif
    #2;
    chk("rst_ack_dat", 64'({ack, rdat}), 64'd0);
    chk("rst_strobes", 64'({m_cyc, m_stb}), 64'd0);
    chk("rst_bus", 64'({m_we, m_sel, m_adr}), 64'd0);
    chk("rst_misc", 64'({m_dat, err, to_ch}), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // Read ch2
    start(32'h3020_0010, 1'b0, 4'hF, 32'h0);
    tick;
    chk("rd2_cyc", 64'(m_cyc), 64'h4);
    chk("rd2_stb", 64'(m_stb), 64'h4);
    chk("rd2_adr", 64'(m_adr), 64'h3020_0010);
    m_ack_i = 4'b0100;
    m_dat_i[64 +: 32] = 32'h1234_5678;
    tick;
    m_ack_i = '0;
    chk("rd2_stb_drop", 64'({ack, m_stb}), 64'd0);
    tick;
    chk("rd2_ack", 64'({ack, rdat}), 64'({1'b1, 32'h1234_5678}));
    idle_bus;
    tick;
    chk("rd2_ack_once", 64'(ack), 64'd0);

    // Write ch0
    start(32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_0000);
    tick;
    chk("wr0_stb", 64'({m_cyc, m_stb}), 64'h11);
    chk("wr0_ctl", 64'({m_we, m_sel}), 64'h13);
    chk("wr0_dat", 64'(m_dat), 64'hA5A5_0000);
    m_ack_i = 4'b0001;
    tick;
    m_ack_i = '0;
    tick;
    chk("wr0_ack", 64'(ack), 64'd1);
    idle_bus;
    tick;
    chk("wr0_single", 64'({ack, m_stb}), 64'd0);
    tick;

    // Decode misses: wrong region, then out-of-range channel
    start(32'h4000_0000, 1'b0, 4'hF, 32'h0);
    tick;
    chk("miss4_nostb", 64'({m_cyc, m_stb, ack}), 64'd0);
    chk("miss4_err", 64'(err), 64'd1);
    tick;
    chk("miss4_ack", 64'({ack, rdat, err}), 64'({1'b1, 32'hDEAD_BEEF, 1'b0}));
    idle_bus;
    tick;
    start(32'h3050_0000, 1'b0, 4'hF, 32'h0);
    tick;
    chk("miss5_nostb", 64'({m_cyc, m_stb, ack, err}), 64'd1);
    tick;
    chk("miss5_ack", 64'({ack, rdat}), 64'({1'b1, 32'hDEAD_BEEF}));
    idle_bus;
    tick;

    // Timeout on ch1: strobe held exactly 8 cycles
    start(32'h3010_0000, 1'b0, 4'hF, 32'h0);
    tick;
    chk("to1_stb", 64'(m_stb), 64'h2);
    repeat (7) tick;
    chk("to1_stb_last", 64'({m_stb, err}), 64'h4);
    tick;
    chk("to1_drop", 64'({m_cyc, m_stb, ack}), 64'd0);
    chk("to1_err", 64'({err, to_ch}), 64'h5);
    tick;
    chk("to1_ack", 64'({ack, rdat, err}), 64'({1'b1, 32'hDEAD_BEEF, 1'b0}));
    idle_bus;
    m_ack_i = 4'b0010;
    tick;
    chk("to1_late_ack", 64'({ack, m_stb}), 64'd0);
    tick;
    chk("to1_late_ack2", 64'({ack, m_stb, err}), 64'd0);
    m_ack_i = '0;

    // Upstream abort in REQ cycle 2
    start(32'h3030_0000, 1'b0, 4'hF, 32'h0);
    tick;
    chk("ab_stb", 64'(m_stb), 64'h8);
    tick;
    idle_bus;
    tick;
    chk("ab_drop", 64'({m_cyc, m_stb, ack, err}), 64'd0);
    repeat (2) tick;
    chk("ab_noack", 64'(ack), 64'd0);

    // Reset mid-REQ
    start(32'h3020_0000, 1'b1, 4'h5, 32'h0BAD_0BAD);
    tick;
    chk("rr_stb", 64'(m_stb), 64'h4);
    tick;
    rst_n = 1'b0;
    idle_bus;
    #1;
    chk("rr_async_strobes", 64'({m_cyc, m_stb, ack, err}), 64'd0);
    chk("rr_async_bus", 64'({m_we, m_sel, m_adr}), 64'd0);
    chk("rr_async_misc", 64'({m_dat, rdat}), 64'd0);
    chk("rr_to_ch", 64'(to_ch), 64'd0);
    tick;
    rst_n = 1'b1;
    repeat (2) tick;
    chk("rr_noack", 64'(ack), 64'd0);

    read_ack("post_rst", 32'h3030_0020, 3, 32'hCAFE_F00D);

`ifdef WB_MPRJ_XBAR_STATS_EN
    read_ack("st_a", 32'h3030_0024, 3, 32'h0000_0011);
    read_ack("st_b", 32'h3030_0028, 3, 32'h0000_0022);
    start(32'h3030_0000, 1'b0, 4'hF, 32'h0);
    repeat (9) tick;
    chk("st_to_err", 64'({err, to_ch}), 64'h7);
    tick;
    idle_bus;
    tick;
    chk("st_cnt3", 64'(stat[48 +: 16]), 64'd3);
    chk("st_cnt_other", 64'(stat[0 +: 48]), 64'd0);
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    chk("st_clr", 64'(stat), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_mprj_xbar.md
Name: wb_mprj_xbar

Overview:
- Parametrised Wishbone fan-out that sits between the management-SoC Wishbone slave port in the user wrapper and NCH user-project peripherals.
- Decodes address, forwards one classic-cycle transaction at a time to the selected channel, and returns data/ack upstream.
- Aborts with an error word on unmapped addresses or downstream timeout, so a hung peripheral cannot stall the management core.

Parameters:
- NCH, 4, number of downstream channels (1..16).
- DW, 32, data width; sel width is DW/8.
- AW, 32, address width.
- BASE, 32'h3000_0000, region base; bits above SEL_LSB+CB must match.
- SEL_LSB, 20, LSB of channel index field adr[SEL_LSB +: CB]; CB = max(1,$clog2(NCH)) (localparam).
- TIMEOUT, 255, REQ-state cycles before forced abort (>=2).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error/timeout.

Ports:
- wb_clk_i  in  1  clock, all logic rising-edge.
- wb_rst_n  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone control.
- wbs_sel_i  in  DW/8  byte selects.
- wbs_adr_i  in  AW  address.
- wbs_dat_i  in  DW  write data.
- wbs_ack_o  out  1  upstream ack, registered.
- wbs_dat_o  out  DW  upstream read data, registered.
- m_cyc_o, m_stb_o  out  NCH  per-channel cyc/stb, one-hot or zero.
- m_we_o  out  1  shared write enable.
- m_sel_o  out  DW/8  shared byte selects.
- m_adr_o  out  AW  shared address, unmodified.
- m_dat_o  out  DW  shared write data.
- m_dat_i  in  NCH*DW  per-channel read data, channel i at [i*DW +: DW].
- m_ack_i  in  NCH  per-channel ack.
- err_o  out  1  one-cycle pulse on decode error or timeout.
- to_ch_o  out  CB  channel index of the most recent timeout.

Behaviour:
- Reset (async, wb_rst_n=0): state=IDLE; wbs_ack_o=0, wbs_dat_o=0, m_cyc_o=m_stb_o=0, m_we_o=0, m_sel_o=0, m_adr_o=0, m_dat_o=0, err_o=0, to_ch_o=0, timeout counter=0.
- Reset mid-transaction drops all strobes immediately; no ack is issued.
- FSM states: IDLE, REQ, RESP.
- IDLE: on wbs_cyc_i & wbs_stb_i & !wbs_ack_o, register adr/we/sel/dat.
  - Decode hit (upper bits == BASE upper bits and ch < NCH): assert m_cyc_o[ch]/m_stb_o[ch] next cycle, go to REQ.
  - Decode miss: go to RESP with wbs_dat_o=ERR_DATA and pulse err_o.
- REQ: counter increments each cycle.
  - m_ack_i[ch]=1: capture m_dat_i[ch] into wbs_dat_o (writes capture too; value don't-care), drop strobes next edge, go to RESP.
  - Counter reaches TIMEOUT with no ack: drop strobes, wbs_dat_o=ERR_DATA, err_o pulse, to_ch_o=ch, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - wbs_cyc_i deasserted (upstream abort): drop strobes, return to IDLE, no ack, no err.
- RESP: wbs_ack_o=1 for exactly one cycle, then IDLE. The !wbs_ack_o guard prevents re-capture of the same request.
- Latency:
  - Hit: request at edge 0, m_stb_o at edge 1, ack_i seen at edge k, wbs_ack_o high during cycle k+1.
  - Minimum 3 cycles request-to-ack for a zero-wait slave.
  - Decode miss: ack 2 cycles after request.
- m_ack_i on non-selected channels, or while in IDLE/RESP, is ignored.
- Counter clears on entry to REQ. It is CB+8 bits wide or wide enough for TIMEOUT, whichever is larger.

Optional Feature:
- Macro WB_MPRJ_XBAR_STATS_EN.
- Defined:
  - Adds ports stat_clr_i (in, 1) and stat_o (out, NCH*16).
  - Per-channel 16-bit saturating counters of completed acked transactions; count increments in the RESP entry cycle.
  - Counters are cleared by reset or by stat_clr_i=1. Clear wins over a same-cycle increment.
  - Saturate at 16'hFFFF.
- Undefined: no ports, no counters; all other behaviour is identical.

Test Plan:
- Read ch2 (adr 32'h3020_0010), slave acks 1 cycle after stb, data 32'h1234_5678 -> only m_stb_o[2] high; wbs_dat_o=32'h1234_5678, wbs_ack_o 1 cycle, 3 cycles after request.
- Write ch0 adr 32'h3000_0004, sel 4'b0011, dat 32'hA5A5_0000 -> m_we_o=1, m_sel_o=4'b0011, m_dat_o matches; single upstream ack.
- Access 32'h4000_0000 and 32'h3050_0000 (ch5, NCH=4) -> no m_stb_o; ack with 32'hDEAD_BEEF after 2 cycles; err_o pulse.
- ch1 never acks, TIMEOUT=8 -> strobes drop after 8 REQ cycles; ack with DEAD_BEEF; to_ch_o=1; err_o pulse. A late m_ack_i[1] afterwards is ignored.
- Upstream drops cyc in REQ cycle 2, then wb_rst_n low mid-REQ on a second access -> no ack in either case; all outputs return to reset values; next access completes normally.
- (STATS_EN) 3 acked accesses to ch3 plus 1 timeout -> stat_o[3*16+:16]=3; stat_clr_i pulse -> 0.
